// File: rtl/joystick_conditioner.sv
// N-channel switch conditioner: 2-flop sync, optional inversion, stable-count debounce, edge pulses.
// Define JOYSTICK_AUTO_REPEAT_EN to build the typematic auto-repeat generator.
module joystick_conditioner #(
  parameter int               N_CH       = 5,
  parameter int               DEB_CYCLES = 16,
  parameter logic [N_CH-1:0]  ACT_LOW    = '0,
  parameter int               REP_DELAY  = 1000,
  parameter int               REP_PERIOD = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_raw,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_repeat,
  output logic            o_any
);

  localparam int             CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [N_CH-1:0]  s1_p0;
  logic [N_CH-1:0]  s2_p1;
  logic [N_CH-1:0]  x_p1;
  logic [N_CH-1:0]  flip_p1;
  logic [N_CH-1:0]  state_p2;
  logic [N_CH-1:0]  state_p3;
  logic [CNT_W-1:0] deb_cnt_p1 [N_CH];

  assign x_p1 = s2_p1 ^ ACT_LOW;

  // A flip happens on the DEB_CYCLES-th consecutive cycle of disagreement.
  always_comb begin
    flip_p1 = '0;
    for (int i = 0; i < N_CH; i++) begin
      flip_p1[i] = (x_p1[i] != state_p2[i]) && (deb_cnt_p1[i] == CNT_LAST);
    end
  end

  // Stage p0/p1: synchroniser; stage p2: debounced state; stage p3: delayed state for edges
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_p0    <= '0;
      s2_p1    <= '0;
      state_p2 <= '0;
      state_p3 <= '0;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_p1[i] <= '0;
      end
    end else begin
      s1_p0    <= i_raw;
      s2_p1    <= s1_p0;
      state_p2 <= state_p2 ^ flip_p1;
      state_p3 <= state_p2;
      for (int i = 0; i < N_CH; i++) begin
        if ((x_p1[i] == state_p2[i]) || flip_p1[i]) begin
          deb_cnt_p1[i] <= '0;
        end else begin
          deb_cnt_p1[i] <= deb_cnt_p1[i] + CNT_W'(1);
        end
      end
    end
  end

  assign o_level = state_p2;

  // Output stage: edge pulses and aggregate level
  always_ff @(posedge clk) begin
    if (rst) begin
      o_press   <= '0;
      o_release <= '0;
      o_any     <= 1'b0;
    end else begin
      o_press   <= state_p2 & ~state_p3;
      o_release <= ~state_p2 & state_p3;
      o_any     <= |state_p2;
    end
  end

`ifdef JOYSTICK_AUTO_REPEAT_EN
  localparam int RC_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;

  typedef enum logic {
    REP_IDLE,
    REP_ARMED
  } rep_state_t;

  rep_state_t      rep_q   [N_CH];
  rep_state_t      rep_d   [N_CH];
  logic [RC_W-1:0] rc_q    [N_CH];
  logic [RC_W-1:0] rc_d    [N_CH];
  logic [N_CH-1:0] rep_pulse_d;

  // A falling flip (flip while state is 1) wins over a same-cycle repeat.
  always_comb begin
    rep_pulse_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      rep_d[i] = rep_q[i];
      rc_d[i]  = rc_q[i];
      case (rep_q[i])
        REP_IDLE: begin
          if (state_p2[i] && !state_p3[i] && !flip_p1[i]) begin
            rc_d[i]  = RC_W'(REP_DELAY - 1);
            rep_d[i] = REP_ARMED;
          end
        end
        REP_ARMED: begin
          if (!state_p2[i] || flip_p1[i]) begin
            rep_d[i] = REP_IDLE;
          end else if (rc_q[i] == '0) begin
            rep_pulse_d[i] = 1'b1;
            rc_d[i]        = RC_W'(REP_PERIOD - 1);
          end else begin
            rc_d[i] = rc_q[i] - RC_W'(1);
          end
        end
        default: rep_d[i] = REP_IDLE;
      endcase
    end
  end

  // Repeat stage: per-channel machine state and registered repeat pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      o_repeat <= '0;
      for (int i = 0; i < N_CH; i++) begin
        rep_q[i] <= REP_IDLE;
        rc_q[i]  <= '0;
      end
    end else begin
      o_repeat <= rep_pulse_d;
      for (int i = 0; i < N_CH; i++) begin
        rep_q[i] <= rep_d[i];
        rc_q[i]  <= rc_d[i];
      end
    end
  end
`else
  // Repeat timing parameters are accepted but have no effect in this build.
  if (REP_DELAY < 1 || REP_PERIOD < 1) begin : g_rep_params_ignored
  end
  assign o_repeat = '0;
`endif

endmodule

// File: tb/tb_joystick_conditioner.sv
// Randomised and directed bench for joystick_conditioner against a cycle-level reference model.
module tb_joystick_conditioner;

  localparam int              N_CH       = 5;
  localparam int              DEB_CYCLES = 4;
  localparam logic [N_CH-1:0] ACT_LOW    = 5'b10000;
  localparam int              REP_DELAY  = 10;
  localparam int              REP_PERIOD = 3;
`ifdef JOYSTICK_AUTO_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] i_raw;
  logic [N_CH-1:0] o_level;
  logic [N_CH-1:0] o_press;
  logic [N_CH-1:0] o_release;
  logic [N_CH-1:0] o_repeat;
  logic            o_any;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  joystick_conditioner #(
    .N_CH      (N_CH),
    .DEB_CYCLES(DEB_CYCLES),
    .ACT_LOW   (ACT_LOW),
    .REP_DELAY (REP_DELAY),
    .REP_PERIOD(REP_PERIOD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (i_raw),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_repeat (o_repeat),
    .o_any    (o_any)
  );

  // Reference model: pin delay line, mismatch run lengths, and press timestamps.
  logic [N_CH-1:0] pin_q1, pin_q2, m_level, m_prev;
  logic [N_CH-1:0] exp_press, exp_release, exp_repeat;
  logic            exp_any;
  int              run_len    [N_CH];
  int              press_edge [N_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input logic r, input logic [N_CH-1:0] raw);
    logic [N_CH-1:0] x;
    logic [N_CH-1:0] lvl_new;
    int              since;
    if (r) begin
      pin_q1 = '0; pin_q2 = '0; m_level = '0; m_prev = '0;
      exp_press = '0; exp_release = '0; exp_repeat = '0; exp_any = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        run_len[i]    = 0;
        press_edge[i] = -1;
      end
    end else begin
      x       = pin_q2 ^ ACT_LOW;
      lvl_new = m_level;
      for (int i = 0; i < N_CH; i++) begin
        if (x[i] != m_level[i]) begin
          run_len[i] = run_len[i] + 1;
          if (run_len[i] == DEB_CYCLES) begin
            lvl_new[i] = x[i];
            run_len[i] = 0;
          end
        end else begin
          run_len[i] = 0;
        end
      end
      exp_press   = m_level & ~m_prev;
      exp_release = ~m_level & m_prev;
      exp_any     = |m_level;
      for (int i = 0; i < N_CH; i++) begin
        if (exp_press[i]) press_edge[i] = cyc;
        if (!lvl_new[i]) press_edge[i] = -1;
        since = cyc - press_edge[i];
        exp_repeat[i] = REP_ON && (press_edge[i] >= 0) && (since >= REP_DELAY) &&
                        (((since - REP_DELAY) % REP_PERIOD) == 0);
      end
      m_prev  = m_level;
      m_level = lvl_new;
      pin_q2  = pin_q1;
      pin_q1  = raw;
    end
  endtask

  task automatic cycle(input logic r, input logic [N_CH-1:0] raw);
    rst   = r;
    i_raw = raw;
    @(posedge clk);
    cyc++;
    model_step(r, raw);
    #1;
    check("level",   32'(o_level),   32'(m_level));
    check("press",   32'(o_press),   32'(exp_press));
    check("release", 32'(o_release), 32'(exp_release));
    check("repeat",  32'(o_repeat),  32'(exp_repeat));
    check("any",     32'(o_any),     32'(exp_any));
    check("press_release_overlap", 32'(o_press & o_release), 32'd0);
  endtask

  initial begin
    int              seen;
    int              first_rep;
    int              cnt_a;
    int              cnt_b;
    logic [N_CH-1:0] raw;

    raw = 5'b10000;
    repeat (3) cycle(1'b1, raw);
    check("reset_state", 32'({o_level, o_press, o_release, o_repeat, o_any}), 32'd0);

    // Scenario 1: clean press on channel 0
    seen = -1;
    raw[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, raw);
      if (o_press[0] && seen < 0) seen = c;
      if (c == 4) check("s1_level_before", 32'(o_level[0]), 32'd0);
      if (c == 5) check("s1_level_edge5",  32'(o_level[0]), 32'd1);
      if (c == 5) check("s1_any_lag",      32'(o_any),      32'd0);
      if (c == 6) check("s1_any_edge6",    32'(o_any),      32'd1);
    end
    check("s1_press_latency", 32'(seen), 32'd6);
    raw[0] = 1'b0;
    repeat (10) cycle(1'b0, raw);

    // Scenario 2: chatter shorter than the debounce window
    cnt_a = 0; cnt_b = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        raw[1] = (c < 3);
        cycle(1'b0, raw);
        if (o_press[1]) cnt_a++;
        if (o_level[1]) cnt_b++;
      end
    end
    raw[1] = 1'b0;
    repeat (8) cycle(1'b0, raw);
    check("s2_chatter_press", 32'(cnt_a), 32'd0);
    check("s2_chatter_level", 32'(cnt_b), 32'd0);

    // Scenario 3: long hold on channel 2; release fall coincides with a repeat slot
    cnt_a = 0; seen = -1; first_rep = -1;
    for (int c = 0; c < 44; c++) begin
      raw[2] = (c < 32);
      cycle(1'b0, raw);
      if (o_repeat[2]) cnt_a++;
      if (o_repeat[2] && first_rep < 0) first_rep = c;
      if (o_press[2]) seen = c;
    end
    check("s3_press_edge",   32'(seen),      32'd6);
    check("s3_repeat_count", 32'(cnt_a),     REP_ON ? 32'd7 : 32'd0);
    check("s3_first_repeat", 32'(first_rep), REP_ON ? 32'd16 : 32'hffffffff);

    // Scenario 4: active-low channel 4 pressed then released
    cnt_a = 0; cnt_b = 0; seen = -1;
    for (int c = 0; c < 24; c++) begin
      raw[4] = (c >= 12);
      cycle(1'b0, raw);
      if (o_press[4]) cnt_a++;
      if (o_press[4] && seen < 0) seen = c;
      if (o_release[4]) cnt_b++;
    end
    check("s4_press_count",   32'(cnt_a), 32'd1);
    check("s4_release_count", 32'(cnt_b), 32'd1);
    check("s4_press_edge",    32'(seen),  32'd6);

    // Scenario 5: simultaneous presses, then reset during a release debounce
    raw[0] = 1'b1; raw[3] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, raw);
      if (c == 6) check("s5_joint_press", 32'(o_press), 32'h09);
    end
    raw[3] = 1'b0;
    repeat (3) cycle(1'b0, raw);
    cycle(1'b1, raw);
    check("s5_reset_clear", 32'({o_level, o_press, o_release, o_repeat, o_any}), 32'd0);
    seen = -1;
    for (int j = 1; j <= 12; j++) begin
      cycle(1'b0, raw);
      if (o_press[0] && seen < 0) seen = j;
    end
    check("s5_repress_edge", 32'(seen), 32'd7);

    // Randomised traffic with occasional reset
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 5) == 0) raw[$urandom_range(0, N_CH - 1)] ^= 1'b1;
      cycle(($urandom_range(0, 199) == 0), raw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
